// File: rtl/aes_ecb_job_arbiter.sv
// Shares one AES-128 ECB core between two block requesters with round-robin grant,
// start/done sequencing, a done timeout and key updates applied only between jobs.
module aes_ecb_job_arbiter #(
    parameter int DATA_W      = 128,
    parameter int KEY_W       = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              key_wr,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic              core_start,
    output logic [KEY_W-1:0]  core_key,
    output logic [DATA_W-1:0] core_din,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_dout,
    output logic              busy,
    output logic [15:0]       jobs_done
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  shadow_q, shadow_d;
    logic              kpend_q, kpend_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       jobs_q, jobs_d;

    logic grant;
    logic start;
    logic rsp_take;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            kpend_q  <= 1'b0;
            key_q    <= '0;
            din_q    <= '0;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            timer_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            jobs_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            kpend_q  <= kpend_d;
            key_q    <= key_d;
            din_q    <= din_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            timer_q  <= timer_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            jobs_q   <= jobs_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        kpend_d  = kpend_q;
        key_d    = key_q;
        din_d    = din_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        timer_d  = timer_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        jobs_d   = jobs_q;
        start    = 1'b0;

        // A lone requester wins outright; a tie (or no request) goes to the favoured side.
        grant = prio_q;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (!req0_valid && req1_valid)
            grant = 1'b1;

        req0_ready = !ARESET && (state_q == IDLE) && !kpend_q && !grant;
        req1_ready = !ARESET && (state_q == IDLE) && !kpend_q && grant;
        rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

        if (key_wr) begin
            shadow_d = key_in;
            kpend_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A pending key is installed alone; a simultaneous write keeps it pending.
                if (kpend_q) begin
                    key_d = shadow_q;
                    if (!key_wr)
                        kpend_d = 1'b0;
                end else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    din_d   = grant ? req1_data : req0_data;
                    owner_d = grant;
                    prio_d  = !grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start   = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    rdata_d = core_dout;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_take) begin
                    state_d = IDLE;
                    if (!err_q)
                        jobs_d = jobs_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_data  = rsp0_valid ? rdata_q : '0;
    assign rsp1_data  = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;
    assign core_start = start;
    assign core_key   = key_q;
    assign core_din   = din_q;
    assign busy       = (state_q != IDLE) || kpend_q;
    assign jobs_done  = jobs_q;

endmodule
